// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues single-outstanding word reads and
// buffers up to two returned instructions for in-order delivery to IF/ID.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] BUBBLE   = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] jump_addr_i,
   input  logic [2:0]  hold_flag_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] inst_addr_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, FULL} state_e;

   state_e      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] deliver_pc_q, deliver_pc_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] fifo_q [2];
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [1:0]  count_q, count_d;
   logic        discard_q, discard_d;
   logic        stale_q, stale_d;

   logic        redirect;
   logic        granted;
   logic        push;
   logic        pop;
   logic [31:0] jump_aligned;

   assign redirect     = (hold_flag_i >= 3'd2);
   assign jump_aligned = jump_addr_i & ~32'd3;
   assign granted      = (state_q == REQ) && ibus_gnt_i;
   assign push         = ibus_rvalid_i && !discard_q && !redirect;
   assign pop          = (hold_flag_i == 3'd0) && (count_q != 2'd0);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ:  if (ibus_gnt_i) state_d = WAIT;
         WAIT: if (ibus_rvalid_i) state_d = (count_d != 2'd2) ? REQ : FULL;
         FULL: if ((count_q != 2'd2) || redirect) state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      ibus_req_o   = (state_q == REQ);
      ibus_addr_o  = addr_q;
      inst_valid_o = (count_q != 2'd0);
      inst_o       = inst_valid_o ? fifo_q[rd_ptr_q] : BUBBLE;
      inst_addr_o  = deliver_pc_q;
   end

   always_comb begin
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      deliver_pc_d = deliver_pc_q;
      if (redirect) begin
         count_d      = 2'd0;
         rd_ptr_d     = 1'b0;
         wr_ptr_d     = 1'b0;
         deliver_pc_d = jump_aligned;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop) begin
            rd_ptr_d     = ~rd_ptr_q;
            deliver_pc_d = deliver_pc_q + 32'd4;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // A request presented before a redirect keeps its address; stale marks it so
   // its eventual response is dropped and the PC does not advance past it.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      discard_d  = discard_q;
      stale_d    = stale_q;
      if (ibus_rvalid_i) discard_d = 1'b0;
      if (granted) begin
         if (stale_q || redirect) discard_d = 1'b1;
         else fetch_pc_d = fetch_pc_q + 32'd4;
         stale_d = 1'b0;
      end
      if (redirect) begin
         fetch_pc_d = jump_aligned;
         if ((state_q == WAIT) && !ibus_rvalid_i) discard_d = 1'b1;
         if ((state_q == REQ) && !ibus_gnt_i) stale_d = 1'b1;
      end
   end

   always_comb begin
      addr_d = addr_q;
      if ((state_d == REQ) && (state_q != REQ)) begin
         addr_d = redirect ? jump_aligned : fetch_pc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q   <= RESET_PC;
         deliver_pc_q <= RESET_PC;
         addr_q       <= RESET_PC;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
         discard_q    <= 1'b0;
         stale_q      <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         deliver_pc_q <= deliver_pc_d;
         addr_q       <= addr_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         discard_q    <= discard_d;
         stale_q      <= stale_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= ibus_rdata_i;
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: vector table for the start-up/stall timeline, directed
// corner sequences, and a randomized run against a stream-level reference model.
module tb_inst_fetch;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] BUBBLE   = 32'h0000_0001;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] jump_addr_i;
   logic [2:0]  hold_flag_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;
   logic [31:0] inst_addr_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic        gnt_en;

   assign ibus_gnt_i = ibus_req_o & gnt_en;
   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(RESET_PC), .BUBBLE(BUBBLE)) dut (
      .clk(clk), .rst(rst), .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
      .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
      .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
      .inst_addr_o(inst_addr_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // bus responder state
   typedef struct { logic [31:0] addr; int due; } pend_t;
   pend_t pend_q[$];
   int gnt_mode = 0;   // 0 always, 1 never, 2 random
   int lat_min  = 1;
   int lat_max  = 1;
   int last_due = -1;

   // reference model state
   logic [31:0] exp_next, exp_fetch, cur_req_addr;
   logic        stale_m;
   logic        have_prev, prev_req, prev_gnt, prev_valid, prev_redirect;
   logic [2:0]  prev_hold;
   int          n_deliv;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %0b expected %0b", name, cyc, act, exp);
      end
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b1;
      hold_flag_i = 3'd0;
      jump_addr_i = 32'd0;
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i = 32'd0;
      gnt_en = 1'b0;
      #1;
      chk1("rst_req", ibus_req_o, 1'b0);
      chk("rst_addr", ibus_addr_o, RESET_PC);
      chk("rst_iaddr", inst_addr_o, RESET_PC);
      chk("rst_inst", inst_o, BUBBLE);
      chk1("rst_valid", inst_valid_o, 1'b0);
      pend_q.delete();
      last_due = -1;
      exp_next = RESET_PC;
      exp_fetch = RESET_PC;
      cur_req_addr = RESET_PC;
      stale_m = 1'b0;
      have_prev = 1'b0;
      prev_req = 1'b0;
      prev_gnt = 1'b0;
      prev_valid = 1'b0;
      prev_redirect = 1'b0;
      prev_hold = 3'd0;
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic drive_bus();
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = 32'hDEAD_BEEF;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         ibus_rvalid_i = 1'b1;
         ibus_rdata_i  = mem_word(pend_q[0].addr);
         pend_q.delete(0);
      end
      case (gnt_mode)
         0:       gnt_en = 1'b1;
         1:       gnt_en = 1'b0;
         default: gnt_en = 1'($urandom_range(0, 1));
      endcase
      #1;
   endtask

   // Stream-level rules: delivered addresses run sequentially from the last
   // redirect target, data matches memory, requests follow the fetch stream.
   task automatic model_check();
      if (ibus_req_o) begin
         chk("one_outstanding", 32'(pend_q.size()), 32'd0);
         if (!(prev_req && !prev_gnt)) cur_req_addr = exp_fetch;
         chk("req_addr", ibus_addr_o, cur_req_addr);
      end else if (have_prev && prev_req && !prev_gnt) begin
         chk1("req_held", ibus_req_o, 1'b1);
      end
      chk("inst_addr", inst_addr_o, exp_next);
      if (have_prev && prev_redirect) chk1("redir_valid", inst_valid_o, 1'b0);
      if (have_prev && prev_hold == 3'd1 && prev_valid) chk1("stall_valid", inst_valid_o, 1'b1);
      if (inst_valid_o) chk("inst_data", inst_o, mem_word(exp_next));
      else chk("bubble", inst_o, BUBBLE);
   endtask

   task automatic model_update();
      int due;
      if (ibus_req_o && ibus_gnt_i) begin
         due = cyc + int'($urandom_range(lat_min, lat_max));
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend_q.push_back('{ibus_addr_o, due});
         if (!stale_m) exp_fetch = exp_fetch + 32'd4;
         stale_m = 1'b0;
      end
      if (hold_flag_i >= 3'd2) begin
         exp_fetch = jump_addr_i & ~32'd3;
         exp_next  = jump_addr_i & ~32'd3;
         if (ibus_req_o && !ibus_gnt_i) stale_m = 1'b1;
      end else if (hold_flag_i == 3'd0 && inst_valid_o) begin
         exp_next = exp_next + 32'd4;
         n_deliv++;
      end
      prev_req      = ibus_req_o;
      prev_gnt      = ibus_gnt_i;
      prev_valid    = inst_valid_o;
      prev_hold     = hold_flag_i;
      prev_redirect = (hold_flag_i >= 3'd2);
      have_prev     = 1'b1;
   endtask

   task automatic begin_cycle(input logic [2:0] h, input logic [31:0] j);
      hold_flag_i = h;
      jump_addr_i = j;
      drive_bus();
      model_check();
   endtask

   task automatic end_cycle();
      model_update();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int c);
      while (cyc < c) begin
         begin_cycle(3'd0, 32'd0);
         end_cycle();
      end
   endtask

   typedef struct {
      logic [2:0]  hold;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] iaddr;
      logic [31:0] inst;
   } vec_t;
   vec_t vecs [22];

   task automatic set_vec(input int k, input logic [2:0] h, input logic r, input logic [31:0] a,
                          input logic v, input logic [31:0] ia);
      vecs[k] = '{h, r, a, v, ia, v ? mem_word(ia) : BUBBLE};
   endtask

   initial begin
      logic [2:0]  h;
      logic [31:0] j;
      int unsigned r;

      // zero-wait start-up, then a 10-cycle stall from cycle 7
      set_vec(0,  3'd0, 1'b0, 32'h00, 1'b0, 32'h00);
      set_vec(1,  3'd0, 1'b1, 32'h00, 1'b0, 32'h00);
      set_vec(2,  3'd0, 1'b0, 32'h00, 1'b0, 32'h00);
      set_vec(3,  3'd0, 1'b1, 32'h04, 1'b1, 32'h00);
      set_vec(4,  3'd0, 1'b0, 32'h04, 1'b0, 32'h04);
      set_vec(5,  3'd0, 1'b1, 32'h08, 1'b1, 32'h04);
      set_vec(6,  3'd0, 1'b0, 32'h08, 1'b0, 32'h08);
      set_vec(7,  3'd1, 1'b1, 32'h0C, 1'b1, 32'h08);
      for (int k = 8; k <= 16; k++) set_vec(k, 3'd1, 1'b0, 32'h0C, 1'b1, 32'h08);
      set_vec(17, 3'd0, 1'b0, 32'h0C, 1'b1, 32'h08);
      set_vec(18, 3'd0, 1'b0, 32'h0C, 1'b1, 32'h0C);
      set_vec(19, 3'd0, 1'b1, 32'h10, 1'b0, 32'h10);
      set_vec(20, 3'd0, 1'b0, 32'h10, 1'b0, 32'h10);
      set_vec(21, 3'd0, 1'b1, 32'h14, 1'b1, 32'h10);

      rst = 1'b1;
      @(negedge clk);
      gnt_mode = 0; lat_min = 1; lat_max = 1;
      apply_reset(2);
      for (int k = 0; k < 22; k++) begin
         begin_cycle(vecs[k].hold, 32'd0);
         chk1("vec_req", ibus_req_o, vecs[k].req);
         chk("vec_addr", ibus_addr_o, vecs[k].addr);
         chk1("vec_valid", inst_valid_o, vecs[k].valid);
         chk("vec_iaddr", inst_addr_o, vecs[k].iaddr);
         chk("vec_inst", inst_o, vecs[k].inst);
         end_cycle();
      end

      // redirect while the response for 8 is still in flight
      apply_reset(1);
      run_to(5);
      lat_min = 3; lat_max = 3;
      begin_cycle(3'd0, 32'd0);
      chk("inflight_addr", ibus_addr_o, 32'h08);
      end_cycle();
      lat_min = 1; lat_max = 1;
      begin_cycle(3'd2, 32'h100); end_cycle();
      begin_cycle(3'd0, 32'd0);
      chk1("inflight_valid0", inst_valid_o, 1'b0);
      chk("inflight_iaddr", inst_addr_o, 32'h100);
      end_cycle();
      begin_cycle(3'd0, 32'd0); end_cycle();
      begin_cycle(3'd0, 32'd0);
      chk1("inflight_drop", inst_valid_o, 1'b0);
      chk("inflight_req", ibus_addr_o, 32'h100);
      end_cycle();
      begin_cycle(3'd0, 32'd0); end_cycle();
      begin_cycle(3'd0, 32'd0);
      chk1("inflight_new_valid", inst_valid_o, 1'b1);
      chk("inflight_new_inst", inst_o, mem_word(32'h100));
      end_cycle();

      // unaligned target near the top of memory wraps to 0
      apply_reset(1);
      begin_cycle(3'd2, 32'hFFFF_FFFE); end_cycle();
      begin_cycle(3'd0, 32'd0);
      chk1("wrap_req1", ibus_req_o, 1'b1);
      chk("wrap_addr1", ibus_addr_o, 32'hFFFF_FFFC);
      end_cycle();
      begin_cycle(3'd0, 32'd0); end_cycle();
      begin_cycle(3'd0, 32'd0);
      chk("wrap_addr2", ibus_addr_o, 32'h0000_0000);
      chk("wrap_iaddr", inst_addr_o, 32'hFFFF_FFFC);
      end_cycle();
      run_to(5);
      begin_cycle(3'd0, 32'd0);
      chk("wrap_iaddr2", inst_addr_o, 32'h0);
      chk("wrap_inst2", inst_o, mem_word(32'h0));
      end_cycle();

      // grant withheld for 5 cycles
      apply_reset(1);
      run_to(1);
      gnt_mode = 1;
      for (int k = 0; k < 5; k++) begin
         begin_cycle(3'd0, 32'd0);
         chk1("bp_req", ibus_req_o, 1'b1);
         chk("bp_addr", ibus_addr_o, 32'h0);
         end_cycle();
      end
      gnt_mode = 0;
      run_to(8);
      begin_cycle(3'd0, 32'd0);
      chk("bp_next_addr", ibus_addr_o, 32'h4);
      chk1("bp_valid", inst_valid_o, 1'b1);
      chk("bp_iaddr", inst_addr_o, 32'h0);
      end_cycle();

      // redirect while the request waits for grant: it goes out, then is dropped
      apply_reset(1);
      gnt_mode = 1;
      run_to(2);
      begin_cycle(3'd2, 32'h200); end_cycle();
      begin_cycle(3'd0, 32'd0);
      chk("stale_addr", ibus_addr_o, 32'h0);
      chk("stale_iaddr", inst_addr_o, 32'h200);
      end_cycle();
      gnt_mode = 0;
      run_to(6);
      begin_cycle(3'd0, 32'd0);
      chk("stale_new_addr", ibus_addr_o, 32'h200);
      chk1("stale_valid", inst_valid_o, 1'b0);
      end_cycle();
      run_to(8);
      begin_cycle(3'd0, 32'd0);
      chk("stale_inst", inst_o, mem_word(32'h200));
      end_cycle();

      // response coincident with redirect is not delivered
      apply_reset(1);
      run_to(2);
      begin_cycle(3'd2, 32'h40);
      chk1("coinc_rvalid", ibus_rvalid_i, 1'b1);
      end_cycle();
      begin_cycle(3'd0, 32'd0);
      chk1("coinc_valid", inst_valid_o, 1'b0);
      chk("coinc_addr", ibus_addr_o, 32'h40);
      end_cycle();
      run_to(5);
      begin_cycle(3'd0, 32'd0);
      chk("coinc_inst", inst_o, mem_word(32'h40));
      end_cycle();

      // push and pop in the same cycle keep one entry buffered
      apply_reset(1);
      run_to(7);
      begin_cycle(3'd1, 32'd0); end_cycle();
      begin_cycle(3'd0, 32'd0); end_cycle();
      begin_cycle(3'd0, 32'd0);
      chk1("pp_valid", inst_valid_o, 1'b1);
      chk("pp_iaddr", inst_addr_o, 32'h0C);
      chk("pp_addr", ibus_addr_o, 32'h10);
      end_cycle();
      begin_cycle(3'd0, 32'd0);
      chk1("pp_empty", inst_valid_o, 1'b0);
      end_cycle();

      // randomized run with occasional mid-transaction resets
      apply_reset(1);
      gnt_mode = 2; lat_min = 1; lat_max = 4;
      n_deliv = 0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 699) == 0) apply_reset(int'($urandom_range(1, 2)));
         r = $urandom_range(0, 99);
         if (r < 65) h = 3'd0;
         else if (r < 88) h = 3'd1;
         else h = 3'($urandom_range(2, 7));
         if ($urandom_range(0, 3) == 0) j = 32'hFFFF_FFF0 | $urandom_range(0, 15);
         else j = $urandom_range(0, 32'h3FFF);
         begin_cycle(h, j);
         end_cycle();
      end
      chk1("liveness", n_deliv > 50, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
